// File: rtl/wide_compare_pkg.sv
// Shared types and constants for the nibble-serial wide comparator.
// Optional build macro used by wide_compare_seq: WIDE_COMPARE_EARLY_EXIT_EN.
package wide_compare_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result vector ordering is {lg, eq, ls}; exactly one bit set for a valid result.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LG   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LS   = 3'b001;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/wide_compare_seq_nibble_cmp4.sv
// Combinational 4-bit compare slice; on the top nibble of a signed compare
// a set sign bit marks the smaller operand.
module nibble_cmp4
  import wide_compare_pkg::*;
(
  input  logic [NIB_W-1:0] na,
  input  logic [NIB_W-1:0] nb,
  input  logic             top_signed,
  output logic             gt,
  output logic             ne
);

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    ne = (na != nb);
    if (top_signed && (na[NIB_W-1] != nb[NIB_W-1])) begin
      gt = nb[NIB_W-1];
    end else begin
      gt = (na > nb);
    end
  end

endmodule

// File: rtl/wide_compare_seq.sv
// Nibble-serial wide comparator, MSB nibble first, valid/ready on both sides.
// Build macro WIDE_COMPARE_EARLY_EXIT_EN: stop at the first differing nibble.
module wide_compare_seq
  import wide_compare_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   sig,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   lg,
  output logic                   eq,
  output logic                   ls,
  output logic                   busy
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sig_q;
  logic [2:0]       res_q;

  logic [NIB_W-1:0] na;
  logic [NIB_W-1:0] nb;
  logic             at_top;
  logic             gt;
  logic             ne;
  logic [2:0]       nib_res;

  assign na      = a_q[NIB_W*idx +: NIB_W];
  assign nb      = b_q[NIB_W*idx +: NIB_W];
  assign at_top  = (idx == IDX_TOP);
  assign nib_res = gt ? RES_LG : RES_LS;

  nibble_cmp4 u_cmp (
    .na         (na),
    .nb         (nb),
    .top_signed (at_top & sig_q),
    .gt         (gt),
    .ne         (ne)
  );

  // NOTE: operand registers are pure datapath, loaded on accept and only read
  // in RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      a_q   <= a;
      b_q   <= b;
      sig_q <= sig;
    end
  end

`ifdef WIDE_COMPARE_EARLY_EXIT_EN

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      res_q <= RES_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            idx   <= IDX_TOP;
            state <= RUN;
          end
        end
        RUN: begin
          if (ne) begin
            res_q <= nib_res;
            state <= DONE;
          end else if (idx == '0) begin
            res_q <= RES_EQ;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  // First-difference verdict is held here and only published on leaving RUN,
  // so lg/eq/ls keep the previous result while lower nibbles are stepped.
  logic       decided;
  logic [2:0] pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      res_q   <= RES_NONE;
      decided <= 1'b0;
      pend_q  <= RES_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            idx     <= IDX_TOP;
            decided <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (idx == '0) begin
            if (decided)  res_q <= pend_q;
            else if (ne)  res_q <= nib_res;
            else          res_q <= RES_EQ;
            state <= DONE;
          end else begin
            if (!decided && ne) begin
              decided <= 1'b1;
              pend_q  <= nib_res;
            end
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

  assign req_ready    = (state == IDLE);
  assign res_valid    = (state == DONE);
  assign busy         = (state != IDLE);
  assign {lg, eq, ls} = res_q;

endmodule

// File: tb/tb_wide_compare_seq.sv
// Self-checking bench for wide_compare_seq: directed table, corner sequences,
// and random requests against a wide-integer reference for NIBBLES=4 and 1.
module tb_wide_compare_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // NIBBLES=4 instance
  logic        req_valid, req_ready, sig, res_valid, res_ready, lg, eq, ls, busy;
  logic [15:0] a, b;

  // NIBBLES=1 instance
  logic        r1_req_valid, r1_req_ready, r1_sig, r1_res_valid, r1_res_ready;
  logic        r1_lg, r1_eq, r1_ls, r1_busy;
  logic [3:0]  r1_a, r1_b;

  int n_checks = 0;
  int n_fail   = 0;

  wide_compare_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .sig(sig), .res_valid(res_valid), .res_ready(res_ready),
    .lg(lg), .eq(eq), .ls(ls), .busy(busy)
  );

  wide_compare_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(r1_req_valid), .req_ready(r1_req_ready),
    .a(r1_a), .b(r1_b), .sig(r1_sig), .res_valid(r1_res_valid),
    .res_ready(r1_res_ready), .lg(r1_lg), .eq(r1_eq), .ls(r1_ls), .busy(r1_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: interpret operands as w-bit integers and compare; result {lg,eq,ls}.
  function automatic logic [2:0] golden(input logic [15:0] x, input logic [15:0] y,
                                        input bit s, input int w);
    longint vx, vy, span;
    span = longint'(1) << w;
    vx = longint'(x) % span;
    vy = longint'(y) % span;
    if (s && vx >= span / 2) vx -= span;
    if (s && vy >= span / 2) vy -= span;
    if (vx > vy)       return 3'b100;
    else if (vx == vy) return 3'b010;
    else               return 3'b001;
  endfunction

  // Cycles from accept to res_valid.
  function automatic int exp_lat(input logic [15:0] x, input logic [15:0] y, input int nibs);
`ifdef WIDE_COMPARE_EARLY_EXIT_EN
    for (int i = nibs - 1; i >= 0; i--)
      if (((x >> (4 * i)) & 16'hF) != ((y >> (4 * i)) & 16'hF)) return nibs - i;
`endif
    return nibs;
  endfunction

  // Called at a negedge with the NIBBLES=4 DUT idle; returns at a negedge, idle.
  task automatic run4(input logic [15:0] ta, input logic [15:0] tb_b, input bit ts,
                      input int hold, input string name);
    int         cyc;
    logic [2:0] exp;
    exp = golden(ta, tb_b, ts, 16);
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    a = ta; b = tb_b; sig = ts; req_valid = 1'b1; res_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sig = 1'($urandom);
    check({name, " busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!res_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(exp_lat(ta, tb_b, 4)));
    check({name, " result"}, 32'({lg, eq, ls}), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; a = ~ta; b = ta;
      @(negedge clk);
      check({name, " hold valid"}, 32'(res_valid), 32'd1);
      check({name, " hold result"}, 32'({lg, eq, ls}), 32'(exp));
      check({name, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, " post valid"}, 32'(res_valid), 32'd0);
    check({name, " post idle"}, 32'({req_ready, busy}), 32'b10);
    check({name, " post held"}, 32'({lg, eq, ls}), 32'(exp));
  endtask

  task automatic run1(input logic [3:0] ta, input logic [3:0] tb_b, input bit ts);
    int         cyc;
    logic [2:0] exp;
    exp = golden({12'h0, ta}, {12'h0, tb_b}, ts, 4);
    r1_a = ta; r1_b = tb_b; r1_sig = ts; r1_req_valid = 1'b1; r1_res_ready = 1'b1;
    @(negedge clk);
    r1_req_valid = 1'b0;
    cyc = 0;
    while (!r1_res_valid && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    check("n1 latency", 32'(cyc), 32'd1);
    check("n1 result", 32'({r1_lg, r1_eq, r1_ls}), 32'(exp));
    @(negedge clk);
    check("n1 idle", 32'({r1_req_ready, r1_res_valid}), 32'b10);
  endtask

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    bit          s;
    logic [2:0]  res;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'h1234, 16'h1234, 1'b0, 3'b010, "eq_1234"};
    vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, "u_8000_7fff"};
    vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 3'b001, "s_8000_7fff"};
    vecs[3] = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b001, "s_fffe_ffff"};
    vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 3'b100, "s_0_m1"};
    vecs[5] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, "s_max_min"};
    vecs[6] = '{16'h1200, 16'h1300, 1'b0, 3'b001, "u_1200_1300"};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 3'b010, "s_eq_ffff"};
    vecs[8] = '{16'h0100, 16'h00FF, 1'b0, 3'b100, "u_0100_00ff"};
    vecs[9] = '{16'h8001, 16'h8000, 1'b1, 3'b100, "s_8001_8000"};

    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; sig = 1'b0;
    r1_req_valid = 1'b0; r1_res_ready = 1'b0; r1_a = '0; r1_b = '0; r1_sig = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset valid/busy", 32'({res_valid, busy}), 32'd0);
    check("reset result", 32'({lg, eq, ls}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors: expected result is hand-derived; also cross-checked with the model.
    foreach (vecs[i]) begin
      check({vecs[i].name, " model"}, 32'(golden(vecs[i].va, vecs[i].vb, vecs[i].s, 16)),
            32'(vecs[i].res));
      run4(vecs[i].va, vecs[i].vb, vecs[i].s, 0, vecs[i].name);
    end

    // Consumer stalls for 5 cycles while upstream presses a new request.
    run4(16'h0030, 16'h0031, 1'b0, 5, "stall");

    // Reset while RUN is at idx 2 (equal operands keep both builds in RUN).
    a = 16'h1234; b = 16'h1234; sig = 1'b0; req_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre-reset busy", 32'({busy, res_valid}), 32'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun reset idle", 32'({req_ready, busy, res_valid}), 32'b100);
    check("midrun reset result", 32'({lg, eq, ls}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no stale result", 32'({res_valid, busy}), 32'd0);
    end
    res_ready = 1'b0;

    // Random back-to-back requests, biased toward equal and near-equal operands.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      run4(ra, rb, 1'($urandom), 0, "rand4");
      check("rand4 onehot", 32'($countones({lg, eq, ls})), 32'd1);
    end

    for (int i = 0; i < 24; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom);
      rb = (i % 4 == 0) ? ra : 4'($urandom);
      run1(ra, rb, 1'($urandom));
      check("n1 onehot", 32'($countones({r1_lg, r1_eq, r1_ls})), 32'd1);
    end
    run1(4'h8, 4'h7, 1'b1);
    check("n1 sign rule", 32'({r1_lg, r1_eq, r1_ls}), 32'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
